apb_bridge_fsm_param: RTL
=========================

# apb_bridge_fsm_param

Parametrised AHB-to-APB bridge controller with wait-state, error and timeout support. It sits between the AHB slave interface and up to NUM_SLV APB peripherals. It accepts one AHB transfer at a time, decodes the target slave from an address field and runs a full APB SETUP/ACCESS cycle that may be stretched by Pready. Slave errors, decode errors and timeouts are returned as a two-cycle AHB ERROR response.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SLV, 3, number of APB slaves (1..8); IDX_W = max(1, clog2(NUM_SLV))
- SEL_LSB, 28, LSB of the slave-index field Haddr[SEL_LSB +: IDX_W]
- TIMEOUT, 16, maximum ACCESS cycles without Pready; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid  in  1  AHB transfer request (HSEL and HTRANS NONSEQ/SEQ)
- Hwrite  in  1  transfer direction, 1 = write
- Haddr  in  ADDR_W  transfer address
- Hwdata  in  DATA_W  write data, valid in the AHB data phase
- Hreadyout  out  1  AHB ready
- Hresp  out  1  AHB error response
- Hrdata  out  DATA_W  read data
- Pselx  out  NUM_SLV  one-hot APB select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Pready  in  1  APB ready
- Prdata  in  DATA_W  APB read data
- Pslverr  in  1  APB slave error
- CS  out  3  current state, exported for the bound checker

## Operation
- State encoding: IDLE=0, WDATA=1, SETUP=2, ACCESS=3, ERR1=4, ERR2=5. Codes 6 and 7 are illegal; the FSM recovers from them to IDLE.
- All outputs are registered.
- Reset values: CS=IDLE, Hreadyout=1, Hresp=0, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, timeout counter=0.
- Acceptance: a transfer is accepted when CS is IDLE or ERR2 and valid=1 (Hreadyout=1 in both states). On acceptance the bridge captures Haddr into Paddr, Hwrite into Pwrite, and the decoded slave index.
- Decode:
  - idx = Haddr[SEL_LSB +: IDX_W].
  - idx < NUM_SLV selects Pselx bit idx.
  - idx >= NUM_SLV is a decode error.
- IDLE/ERR2 transitions:
  - no valid → IDLE
  - decode error → ERR1 (Hwdata is ignored, no APB activity)
  - valid write → WDATA
  - valid read → SETUP
- WDATA: latch Hwdata into Pwdata, then go to SETUP. Hreadyout=0.
- SETUP: Pselx one-hot, Penable=0, Hreadyout=0. Always goes to ACCESS next.
- ACCESS: Pselx held, Penable=1, Hreadyout=0.
  - Pready=1 and Pslverr=0 → IDLE. Hreadyout=1 and Hresp=0 in IDLE. For a read, Hrdata ← Prdata.
  - Pready=1 and Pslverr=1 → ERR1.
  - Pready=0 → stay in ACCESS and increment the counter. When the counter reaches TIMEOUT (TIMEOUT>0), go to ERR1.
- ERR1: Hreadyout=0, Hresp=1, Pselx=0, Penable=0. Always goes to ERR2.
- ERR2: Hreadyout=1, Hresp=1. Transitions are identical to IDLE.
- Hrdata is 0 after any error completion and holds its value otherwise.
- Pready and Pslverr are ignored outside ACCESS.
- Paddr, Pwrite and Pwdata hold their last values when no transfer is in progress.
- Pselx and Penable are 0 in IDLE, WDATA (Pselx only), ERR1 and ERR2.

## Timing
- Read, zero wait states: accept at cycle 0; SETUP at 1; ACCESS at 2; IDLE at 3 with Hreadyout=1 and Hrdata valid. Latency is 3 cycles.
- Write, zero wait states: accept at 0; WDATA at 1; SETUP at 2; ACCESS at 3; IDLE at 4. Latency is 4 cycles.
- Each Pready=0 cycle in ACCESS adds 1 cycle of latency.
- Timeout: with Pready held low, ACCESS lasts exactly TIMEOUT cycles, then ERR1 follows. The counter clears on leaving ACCESS.
- Decode error: accept at 0; ERR1 at 1; ERR2 at 2. A new transfer may be accepted in cycle 2.
- Back-to-back transfers: the next transfer is accepted in the completion cycle (IDLE/ERR2). There is no idle APB cycle beyond the one implied by that.
- The master holds valid, Haddr, Hwrite and Hwdata stable while Hreadyout=0. The bridge samples them only at acceptance (control) and in WDATA (data).
- Reset asserted mid-transfer: all outputs go to reset values immediately and asynchronously. Pselx drops without completing the APB cycle, and the transfer is lost.

## Test plan
- Read Haddr=0x1000_0004, Prdata=0xDEAD_BEEF, Pready=1 → Pselx=3'b010 for cycles 1–2, Penable=1 in cycle 2 only, Hrdata=0xDEAD_BEEF with Hreadyout=1 at cycle 3.
- Write Haddr=0x2000_0010, Hwdata=0x1234_5678, with 3 Pready=0 cycles → Pselx=3'b100, Pwdata=0x1234_5678, Pwrite=1, ACCESS lasts 4 cycles, IDLE at cycle 7.
- Read Haddr=0x3000_0000 (idx 3 ≥ NUM_SLV) → Pselx stays 0; Hresp=1 with Hreadyout=0, then Hresp=1 with Hreadyout=1; a new read accepted in ERR2 reaches SETUP the following cycle.
- Write with Pready=1 and Pslverr=1 → ERR1 then ERR2, Hresp=1 for 2 cycles, Hrdata=0.
- Read with Pready stuck at 0, TIMEOUT=16 → Penable=1 for exactly 16 cycles, then ERR1 and ERR2; CS sequence 2,3×16,4,5.
- rst pulsed during ACCESS of a write → Pselx=0, Penable=0, Hreadyout=1, CS=0 before the next clk edge; a normal read completes after reset is released.

Source files
------------

// File: rtl/apb_bridge_fsm_param_if.sv
// AHB-slave / APB-master signal bundle for apb_bridge_fsm_param.
// Latency: none; this is wiring only.
// Backpressure: carried by Hreadyout (AHB side) and Pready (APB side).
interface apb_bridge_fsm_param_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3
);
  // AHB side
  logic              valid;
  logic              Hwrite;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyout;
  logic              Hresp;
  logic [DATA_W-1:0] Hrdata;
  // APB side
  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [ADDR_W-1:0]  Paddr;
  logic [DATA_W-1:0]  Pwdata;
  logic               Pready;
  logic [DATA_W-1:0]  Prdata;
  logic               Pslverr;
  // exported FSM state
  logic [2:0]         CS;

  // bridge view
  modport slave (
    input  valid, Hwrite, Haddr, Hwdata, Pready, Prdata, Pslverr,
    output Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata, CS
  );

  // environment view (AHB master plus APB peripherals)
  modport master (
    output valid, Hwrite, Haddr, Hwdata, Pready, Prdata, Pslverr,
    input  Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata, CS
  );
endinterface

// File: rtl/apb_bridge_fsm_param.sv
// AHB-to-APB bridge: one transfer at a time, slave decode, wait states, slave/decode errors, timeout.
// Latency: read 3 cycles, write 4 cycles, +1 per Pready=0 cycle; errors return a 2-cycle ERROR response.
// Backpressure: Hreadyout=0 while a transfer is in flight; APB side stretched by Pready.
module apb_bridge_fsm_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  apb_bridge_fsm_param_if.slave bus
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_hreadyout;
  logic               r_hresp;
  logic [DATA_W-1:0]  r_hrdata;
  logic [NUM_SLV-1:0] r_pselx;
  logic               r_penable;
  logic               r_pwrite;
  logic [ADDR_W-1:0]  r_paddr;
  logic [DATA_W-1:0]  r_pwdata;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic [IDX_W-1:0]   w_idx;
  logic               w_dec_err;
  logic [NUM_SLV-1:0] w_sel_new;
  logic [NUM_SLV-1:0] w_sel_held;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_timeout;

  // Slave index comes straight off the address; out-of-range indices are decode errors.
  assign w_idx      = bus.Haddr[SEL_LSB +: IDX_W];
  assign w_dec_err  = ({1'b0, w_idx} >= (IDX_W + 1)'(NUM_SLV));
  assign w_sel_new  = NUM_SLV'(1) << w_idx;
  assign w_sel_held = NUM_SLV'(1) << r_idx;

  // Timeout fires on the TIMEOUT-th consecutive ACCESS cycle without Pready.
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_timeout  = (TIMEOUT > 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

  assign bus.CS        = r_state;
  assign bus.Hreadyout = r_hreadyout;
  assign bus.Hresp     = r_hresp;
  assign bus.Hrdata    = r_hrdata;
  assign bus.Pselx     = r_pselx;
  assign bus.Penable   = r_penable;
  assign bus.Pwrite    = r_pwrite;
  assign bus.Paddr     = r_paddr;
  assign bus.Pwdata    = r_pwdata;

  // Bridge FSM; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_pselx     <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        // IDLE and ERR2 both complete a transfer and may accept the next one.
        S_IDLE, S_ERR2: begin
          if (bus.valid) begin
            r_paddr     <= bus.Haddr;
            r_pwrite    <= bus.Hwrite;
            r_idx       <= w_idx;
            r_hreadyout <= 1'b0;
            if (w_dec_err) begin
              // no APB cycle at all; straight into the error response
              r_state  <= S_ERR1;
              r_hresp  <= 1'b1;
              r_hrdata <= '0;
            end else if (bus.Hwrite) begin
              r_state <= S_WDATA;
              r_hresp <= 1'b0;
            end else begin
              r_state <= S_SETUP;
              r_hresp <= 1'b0;
              r_pselx <= w_sel_new;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end

        // AHB data phase: write data is only valid now.
        S_WDATA: begin
          r_pwdata <= bus.Hwdata;
          r_pselx  <= w_sel_held;
          r_state  <= S_SETUP;
        end

        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (bus.Pready) begin
            r_pselx   <= '0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            if (bus.Pslverr) begin
              r_state  <= S_ERR1;
              r_hresp  <= 1'b1;
              r_hrdata <= '0;
            end else begin
              r_state     <= S_IDLE;
              r_hreadyout <= 1'b1;
              if (!r_pwrite) begin
                r_hrdata <= bus.Prdata;
              end
            end
          end else if (w_timeout) begin
            // abandon the peripheral and report an error
            r_pselx   <= '0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_ERR1;
            r_hresp   <= 1'b1;
            r_hrdata  <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // second half of the two-cycle ERROR response
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end

        // codes 6/7: drop everything and return to a clean IDLE
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
          r_pselx     <= '0;
          r_penable   <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

endmodule
